approx_pp_accumulator: RTL
==========================

# approx_pp_accumulator

Sequential approximate multiplier core that generates one partial-product row per cycle and accumulates it into a running product register. The accumulator's adder is split at a configurable column: low columns use a carry-free OR approximation, high columns use an exact ripple add built from the team's half/full adder cells. It sits directly upstream of result consumers. It accepts operands on a valid/ready handshake and presents the product on a valid/ready handshake.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- APPROX_BITS, 4, number of low product columns using OR approximation (0 ≤ APPROX_BITS ≤ 2*WIDTH; 0 = exact multiplier)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a, b valid
- in_ready  output  1  core can accept operands
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  approximate unsigned product

## Operation
- States: IDLE, ACCUM, DONE; encoding is free.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready, latch a_r=a and b_r=b, clear acc=0 and cnt=0, then go to ACCUM.
- ACCUM: in_ready=0, out_valid=0. Each cycle:
  - row = b_r[cnt] ? ({WIDTH'b0,a_r} << cnt) : 0
  - acc ← approx_add(acc,row)
  - cnt ← cnt+1
  - When cnt==WIDTH-1 is processed, go to DONE.
- approx_add(x,y), 2*WIDTH bits:
  - Bits [APPROX_BITS-1:0] = x|y bitwise; no carry is generated out of this region.
  - Bits [2*WIDTH-1:APPROX_BITS] = exact sum of the upper slices with carry-in 0; carry-out of the MSB is discarded.
- DONE:
  - out_valid=1, product=acc, in_ready=0.
  - On out_valid&out_ready, go to IDLE.
  - product and out_valid hold stable while out_ready=0.
- product is driven from acc at all times; its value is only meaningful while out_valid=1.
- Rows with b_r[cnt]=0 still consume one cycle. There is no early termination, so latency is data-independent.
- Result is always ≤ exact product; it equals the exact product when no two accumulated rows have overlapping 1s in the low APPROX_BITS columns.

## Timing
- Reset (async assert, synchronous-safe deassert):
  - state=IDLE, acc=0, cnt=0, a_r=0, b_r=0
  - in_ready=1, out_valid=0, product=0
- Reset asserted mid-ACCUM or mid-DONE aborts the operation immediately; the pending product is lost and no out_valid pulse follows.
- Acceptance edge E0. ACCUM occupies edges E1..E_WIDTH; out_valid rises after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
- Earliest next acceptance is the edge after the out_valid&out_ready handshake. IDLE lasts at least one cycle, so throughput is one product per WIDTH+2 cycles at best.
- in_valid while in_ready=0 is ignored. a/b are sampled only at acceptance, and later changes have no effect.
- out_ready high before out_valid has no effect.
- cnt width is clog2(WIDTH); no wrap occurs beyond WIDTH-1.

## Test plan
- Reset values:
  - Assert rst mid-ACCUM (a=15, b=15, 3 cycles in) → in_ready=1, out_valid=0, product=0 immediately.
  - After release, no stray out_valid.
- Approximation, WIDTH=8, APPROX_BITS=4:
  - a=15, b=15 → product=191 (0x00BF); exact would be 225.
  - out_valid appears exactly 8 cycles after the accept edge.
- Exact-region cases, APPROX_BITS=4:
  - a=16, b=255 → 4080.
  - a=255, b=128 → 32640.
  - a=0, b=200 → 0.
  - a=255, b=1 → 255.
- Exact mode, APPROX_BITS=0:
  - a=255, b=255 → 65025.
  - a=15, b=15 → 225.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → product/out_valid stable, in_ready=0.
  - Toggle a/b and in_valid during this window → no effect on the result.
  - Raise out_ready → single handshake, then IDLE.
- Back-to-back: in_valid held high with new operands each handshake → consecutive acceptances spaced WIDTH+2 cycles, each result matching the model.

Source files
------------

// File: rtl/approx_pp_accumulator.sv
// Sequential shift-and-add multiplier: one partial-product row per cycle, accumulated
// through an adder whose low APPROX_BITS columns are carry-free OR and upper columns exact.

module approx_pp_half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module approx_pp_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic s1;
  logic c1;
  logic c2;

  approx_pp_half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s1),  .c_o(c1));
  approx_pp_half_adder u_ha1 (.a_i(s1),  .b_i(c_i), .s_o(s_o), .c_o(c2));

  assign c_o = c1 | c2;
endmodule

module approx_pp_accumulator #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PW-1:0]     row;
  logic [PW-1:0]     sum;
  logic [PW-1:0]     carry;

  assign row = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;

  // The carry chain enters the exact region as 0; OR columns just forward that 0 upward.
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < PW; i++) begin : g_col
    if (i < APPROX_BITS) begin : g_or
      assign sum[i] = acc_q[i] | row[i];
      if (i < PW - 1) begin : g_fwd
        assign carry[i+1] = carry[i];
      end
    end else if (i == PW - 1) begin : g_msb
      // Carry-out of the top column is discarded, so only its sum bit is formed.
      assign sum[i] = acc_q[i] ^ row[i] ^ carry[i];
    end else begin : g_fa
      approx_pp_full_adder u_fa (
        .a_i (acc_q[i]),
        .b_i (row[i]),
        .c_i (carry[i]),
        .s_o (sum[i]),
        .c_o (carry[i+1])
      );
    end
  end

  // NOTE: every output and next-state signal gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = sum;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign product = acc_q;

endmodule
